bsg_nonce_collector: RTL and testbench
======================================

// Module: bsg_nonce_collector
// PURPOSE
//  Result end of the nonce-search interface. Each mining core takes nonces from its
//  nonce counter and hands back (nonce, hash-high-word) pairs. This block picks those
//  results up from NUM_CORES_P cores and checks each hash against the difficulty target.
//  It reports one verdict per search to the host: winning nonce, or exhausted.
// PARAMETERS
//  NUM_CORES_P  4   number of result sources (cores); >=1
//  WIDTH_P      32  nonce / hash-word / target / count width
// PORTS
//  clk_i            in   1                   clock
//  reset_i          in   1                   synchronous, active-high reset
//  start_i          in   1                   arm a new search; clears count/capture
//  target_i         in   WIDTH_P             hit when hash_hi <= target_i (unsigned)
//  limit_i          in   WIDTH_P             total results expected per search
//  res_v_i          in   NUM_CORES_P         per-core result valid
//  res_nonce_i      in   NUM_CORES_P*WIDTH_P core k at [k*WIDTH_P +: WIDTH_P]
//  res_hash_hi_i    in   NUM_CORES_P*WIDTH_P hash bits [255:224] per core, same packing
//  res_yumi_o       out  NUM_CORES_P         one-hot accept, same cycle as valid
//  done_v_o         out  1                   verdict valid
//  done_found_o     out  1                   1 = hit, 0 = limit reached with no hit
//  done_nonce_o     out  WIDTH_P             winning nonce (0 when found=0)
//  done_ready_i     in   1                   host accepts verdict
//  checked_o        out  WIDTH_P             results consumed this search
//  busy_o           out  1                   state == SEARCH
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; RR pointer at core 0.
//  - IDLE: res_yumi_o=0. start_i -> SEARCH next cycle, checked_o=0, capture cleared.
//  - SEARCH: at most one result per cycle.
//    - Round-robin grant over res_v_i, starting at the core after the last granted.
//    - res_yumi_o[g]=1 combinationally with res_v_i[g]; checked_o increments.
//    - Hit (hash_hi <= target_i): latch nonce; -> REPORT, found=1.
//    - Non-hit, checked_o+1 == limit_i: -> REPORT, found=0.
//    - Hit on the limit result: found=1 wins.
//    - limit_i==0: never terminates on count (hit only).
//  - REPORT: done_v_o=1; outputs stable, res_yumi_o=0.
//    - done_v_o & done_ready_i -> IDLE the next cycle.
//  - Latency: grant of hit result -> done_v_o is 1 cycle (registered).
//  - start_i in SEARCH or REPORT: abort; restart SEARCH cleared next cycle.
//    - No yumi that cycle; pending verdict dropped.
//  - checked_o wraps modulo 2^WIDTH_P; target/limit sampled each cycle, host keeps them stable.
// CONFIGURATION
//  BSG_NONCE_COLLECT_BEST_EN
//    defined:   a hit does not end the search. Keep the smallest hash_hi seen
//               (ties: earlier result). REPORT only at limit; found=1 if any hit.
//    undefined: first hit ends the search (as above).
// STRUCTURE
//  - bsg_nonce_pkg: WIDTH constant, state enum {IDLE, SEARCH, REPORT} (2-bit).
//  - Sub-module bsg_nonce_rr_arb (NUM_CORES_P): req vector -> one-hot grant + index;
//    pointer advances only on grant.
//  - Top: FSM, hit compare, capture regs, count.
// TESTING
//  1. 1 core, target=0x0000FFFF, limit=8. Hashes 0xFFFFFFFF x3, then 0x00001234 with
//     nonce 0x1003. -> done found=1, nonce=0x1003, checked=4, one cycle after grant.
//  2. 4 cores, all valid every cycle, no hit, limit=12. -> grants 0,1,2,3 repeating,
//     3 each; done found=0, nonce=0, checked=12.
//  3. Hit on 8th result with limit=8. -> found=1. Hold done_ready_i=0 5 cycles:
//     outputs stable, yumi=0. Then ready=1 -> IDLE next cycle.
//  4. start_i mid-SEARCH after 3 results -> checked=0 next cycle, no yumi that cycle,
//     search completes normally afterward.
//  5. Reset asserted in REPORT -> done_v_o=0, state IDLE, checked_o=0 next cycle.
//  6. BEST_EN: limit=4, hashes 0x00000500, 0x00000100, 0x00000100, 0xFFFFFFFF,
//     target=0x00001000 -> found=1, nonce of 2nd result, done after 4th.

Source files
------------

// File: rtl/bsg_nonce_pkg.sv
// Shared constants and state encoding for the nonce result collector.
package bsg_nonce_pkg;

   localparam int WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      REPORT = 2'd2
   } state_e;

endpackage

// File: rtl/bsg_nonce_rr_arb.sv
// Round-robin arbiter: one-hot grant plus index, priority starts after the last grant.
// The pointer moves only when a grant is actually issued (en_i high).
module bsg_nonce_rr_arb #(
   parameter int NUM_CORES_P = 4,
   parameter int IDX_W       = (NUM_CORES_P > 1) ? $clog2(NUM_CORES_P) : 1
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   en_i,
   input  logic [NUM_CORES_P-1:0] req_i,
   output logic [NUM_CORES_P-1:0] grant_o,
   output logic [IDX_W-1:0]       idx_o,
   output logic                   v_o
);

   logic [IDX_W-1:0]         ptr;
   logic [2*NUM_CORES_P-1:0] dbl;
   logic [NUM_CORES_P-1:0]   rot;
   logic                     found;
   int                       idx_int;

   // Rotate the requests so bit 0 is the highest-priority core.
   always_comb begin
      dbl     = {req_i, req_i};
      rot     = NUM_CORES_P'(dbl >> ptr);
      found   = 1'b0;
      idx_int = 0;
      for (int i = 0; i < NUM_CORES_P; i++) begin
         if (!found && rot[i]) begin
            found   = 1'b1;
            idx_int = int'(ptr) + i;
            if (idx_int >= NUM_CORES_P) idx_int = idx_int - NUM_CORES_P;
         end
      end
   end

   assign idx_o   = IDX_W'(idx_int);
   assign v_o     = en_i & found;
   assign grant_o = v_o ? (NUM_CORES_P'(1) << idx_o) : '0;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr <= '0;
      end else if (v_o) begin
         if (int'(idx_o) == NUM_CORES_P - 1) ptr <= '0;
         else                                ptr <= idx_o + IDX_W'(1);
      end
   end

endmodule

// File: rtl/bsg_nonce_collector.sv
// Collects (nonce, hash_hi) results from the mining cores and reports one verdict per search.
// BSG_NONCE_COLLECT_BEST_EN: keep the smallest hit seen and report only at the limit.
//
// state  | meaning
// IDLE   | waiting for start_i, no results accepted
// SEARCH | accepting one result per cycle, comparing against target
// REPORT | verdict held on done_* until the host takes it
module bsg_nonce_collector
   import bsg_nonce_pkg::*;
#(
   parameter int NUM_CORES_P = 4,
   parameter int WIDTH_P     = WIDTH
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic                           start_i,
   input  logic [WIDTH_P-1:0]             target_i,
   input  logic [WIDTH_P-1:0]             limit_i,
   input  logic [NUM_CORES_P-1:0]         res_v_i,
   input  logic [NUM_CORES_P*WIDTH_P-1:0] res_nonce_i,
   input  logic [NUM_CORES_P*WIDTH_P-1:0] res_hash_hi_i,
   output logic [NUM_CORES_P-1:0]         res_yumi_o,
   output logic                           done_v_o,
   output logic                           done_found_o,
   output logic [WIDTH_P-1:0]             done_nonce_o,
   input  logic                           done_ready_i,
   output logic [WIDTH_P-1:0]             checked_o,
   output logic                           busy_o
);

   localparam int IDX_W = (NUM_CORES_P > 1) ? $clog2(NUM_CORES_P) : 1;

   state_e                 state;
   logic [WIDTH_P-1:0]     checked_r;
   logic [WIDTH_P-1:0]     nonce_r;
   logic                   found_r;
   logic                   grant_en;
   logic                   grant_v;
   logic [IDX_W-1:0]       grant_idx;
   logic [NUM_CORES_P-1:0] grant;
   logic [WIDTH_P-1:0]     sel_nonce;
   logic [WIDTH_P-1:0]     sel_hash;
   logic [WIDTH_P-1:0]     checked_nx;
   logic                   hit;
   logic                   at_limit;
`ifdef BSG_NONCE_COLLECT_BEST_EN
   logic [WIDTH_P-1:0]     best_r;
   logic                   better;
`endif

   // A start request takes priority over accepting a result in the same cycle.
   assign grant_en = (state == SEARCH) && !start_i;

   bsg_nonce_rr_arb #(
      .NUM_CORES_P (NUM_CORES_P),
      .IDX_W       (IDX_W)
   ) u_arb (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (grant_en),
      .req_i   (res_v_i),
      .grant_o (grant),
      .idx_o   (grant_idx),
      .v_o     (grant_v)
   );

   assign sel_nonce  = res_nonce_i[int'(grant_idx)*WIDTH_P +: WIDTH_P];
   assign sel_hash   = res_hash_hi_i[int'(grant_idx)*WIDTH_P +: WIDTH_P];
   assign hit        = (sel_hash <= target_i);
   assign checked_nx = checked_r + WIDTH_P'(1);
   // limit of zero means the count never ends the search
   assign at_limit   = (limit_i != '0) && (checked_nx == limit_i);
`ifdef BSG_NONCE_COLLECT_BEST_EN
   assign better     = hit && (!found_r || (sel_hash < best_r));
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state     <= IDLE;
         checked_r <= '0;
         nonce_r   <= '0;
         found_r   <= 1'b0;
`ifdef BSG_NONCE_COLLECT_BEST_EN
         best_r    <= '1;
`endif
      end else if (start_i) begin
         state     <= SEARCH;
         checked_r <= '0;
         nonce_r   <= '0;
         found_r   <= 1'b0;
`ifdef BSG_NONCE_COLLECT_BEST_EN
         best_r    <= '1;
`endif
      end else begin
         case (state)
            IDLE: ;
            SEARCH: begin
               if (grant_v) begin
                  checked_r <= checked_nx;
`ifdef BSG_NONCE_COLLECT_BEST_EN
                  if (better) begin
                     found_r <= 1'b1;
                     nonce_r <= sel_nonce;
                     best_r  <= sel_hash;
                  end
                  if (at_limit) state <= REPORT;
`else
                  if (hit) begin
                     found_r <= 1'b1;
                     nonce_r <= sel_nonce;
                     state   <= REPORT;
                  end else if (at_limit) begin
                     state   <= REPORT;
                  end
`endif
               end
            end
            REPORT: begin
               if (done_ready_i) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign res_yumi_o   = grant;
   assign done_v_o     = (state == REPORT);
   assign busy_o       = (state == SEARCH);
   assign done_found_o = done_v_o & found_r;
   assign done_nonce_o = (done_v_o && found_r) ? nonce_r : '0;
   assign checked_o    = checked_r;

endmodule

// File: tb/tb_bsg_nonce_collector.sv
// Scoreboard bench for bsg_nonce_collector: expected grants/verdicts queued from a bench model.
module tb_bsg_nonce_collector;

   localparam int N = 4;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           reset_i;
   logic           start;
   logic [W-1:0]   target;
   logic [W-1:0]   limit;
   logic [N-1:0]   res_v;
   logic [N*W-1:0] res_nonce;
   logic [N*W-1:0] res_hash;
   logic [N-1:0]   yumi;
   logic           done_v;
   logic           done_found;
   logic [W-1:0]   done_nonce;
   logic           done_ready;
   logic [W-1:0]   checked;
   logic           busy;

   typedef struct packed {
      logic         found;
      logic [W-1:0] nonce;
      logic [W-1:0] checked;
   } verdict_t;

   verdict_t sb[$];
   int       exp_g[$];
   int       checks = 0;
   int       errors = 0;
   int       m_ptr  = 0;

   always #5 clk = ~clk;

   bsg_nonce_collector #(.NUM_CORES_P(N), .WIDTH_P(W)) dut (
      .clk_i         (clk),
      .reset_i       (reset_i),
      .start_i       (start),
      .target_i      (target),
      .limit_i       (limit),
      .res_v_i       (res_v),
      .res_nonce_i   (res_nonce),
      .res_hash_hi_i (res_hash),
      .res_yumi_o    (yumi),
      .done_v_o      (done_v),
      .done_found_o  (done_found),
      .done_nonce_o  (done_nonce),
      .done_ready_i  (done_ready),
      .checked_o     (checked),
      .busy_o        (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_res();
      res_v = '0; res_nonce = '0; res_hash = '0;
   endtask

   task automatic put(input int k, input logic [W-1:0] n, input logic [W-1:0] h);
      res_v[k] = 1'b1;
      res_nonce[k*W +: W] = n;
      res_hash[k*W +: W]  = h;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      tick(); tick();
      reset_i = 1'b0;
      #1;
      checks++; if (done_v !== 1'b0)  begin errors++; $display("FAIL reset_done_v got %b want 0", done_v); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (checked !== '0)   begin errors++; $display("FAIL reset_checked got %h want 0", checked); end
      checks++; if (yumi !== '0)      begin errors++; $display("FAIL reset_yumi got %b want 0", yumi); end
      checks++; if (done_found !== 1'b0 || done_nonce !== '0)
         begin errors++; $display("FAIL reset_done_data got %b/%h want 0/0", done_found, done_nonce); end
      m_ptr = 0;
   endtask

   task automatic test_single_hit();
      logic [W-1:0] h[4];
      logic [W-1:0] tgt;
      verdict_t     v;
      int           cnt;
      bit           hit;
      h = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00001234};
      tgt = 32'h0000FFFF; cnt = 0; hit = 0;
      target = tgt; limit = 32'd8;
      do_start();
      for (int i = 0; i < 4; i++) begin
         clr_res(); put(0, 32'h1000 + i, h[i]);
         if (!hit) begin
            cnt++; m_ptr = 1;
            if (h[i] <= tgt) begin
               hit = 1;
               sb.push_back('{found: 1'b1, nonce: W'(32'h1000 + i), checked: W'(cnt)});
            end
         end
         #1;
         checks++; if (yumi !== 4'b0001) begin errors++; $display("FAIL t1_yumi[%0d] got %b want 0001", i, yumi); end
         tick();
      end
      clr_res(); #1;
      v = sb.pop_front();
      checks++; if (done_v !== 1'b1) begin errors++; $display("FAIL t1_latency done_v got %b want 1", done_v); end
      checks++; if ({done_found, done_nonce, checked} !== v)
         begin errors++; $display("FAIL t1_verdict got %b/%h/%0d want %b/%h/%0d", done_found, done_nonce, checked, v.found, v.nonce, v.checked); end
      done_ready = 1'b1; tick(); done_ready = 1'b0; #1;
      checks++; if (done_v !== 1'b0 || busy !== 1'b0)
         begin errors++; $display("FAIL t1_idle got done_v=%b busy=%b want 0/0", done_v, busy); end
   endtask

   task automatic test_rr_no_hit();
      int       obs[N];
      verdict_t v;
      logic [N-1:0] e;
      int       g;
      target = '0; limit = 32'd12;
      for (int k = 0; k < N; k++) obs[k] = 0;
      for (int i = 0; i < 12; i++) begin
         exp_g.push_back(m_ptr);
         m_ptr = (m_ptr + 1) % N;
      end
      sb.push_back('{found: 1'b0, nonce: '0, checked: W'(12)});
      do_start();
      clr_res();
      for (int k = 0; k < N; k++) put(k, 32'h2000 + k, 32'h80000000 | k);
      for (int i = 0; i < 12; i++) begin
         #1;
         g = exp_g.pop_front();
         e = '0; e[g] = 1'b1;
         checks++; if (yumi !== e) begin errors++; $display("FAIL t2_grant[%0d] got %b want %b", i, yumi, e); end
         for (int k = 0; k < N; k++) obs[k] += int'(yumi[k]);
         tick();
      end
      #1;
      v = sb.pop_front();
      checks++; if (yumi !== '0) begin errors++; $display("FAIL t2_report_yumi got %b want 0", yumi); end
      checks++; if ({done_v, done_found, done_nonce, checked} !== {1'b1, v})
         begin errors++; $display("FAIL t2_verdict got %b/%b/%h/%0d want 1/%b/%h/%0d", done_v, done_found, done_nonce, checked, v.found, v.nonce, v.checked); end
      for (int k = 0; k < N; k++) begin
         checks++; if (obs[k] != 3) begin errors++; $display("FAIL t2_share core%0d got %0d want 3", k, obs[k]); end
      end
      clr_res();
      done_ready = 1'b1; tick(); done_ready = 1'b0;
   endtask

   task automatic test_hold_report();
      logic [W-1:0] tgt;
      logic [W-1:0] hh;
      verdict_t     v;
      int           cnt;
      bit           done;
      tgt = 32'h00000100; cnt = 0; done = 0;
      target = tgt; limit = 32'd8;
      do_start();
      for (int i = 0; i < 8; i++) begin
         hh = (i == 7) ? 32'h00000100 : 32'h00000101;
         clr_res(); put(2, 32'h3000 + i, hh);
         if (!done) begin
            cnt++; m_ptr = 3;
            if (hh <= tgt) begin done = 1; sb.push_back('{found: 1'b1, nonce: W'(32'h3000 + i), checked: W'(cnt)}); end
            else if (cnt == 8) begin done = 1; sb.push_back('{found: 1'b0, nonce: '0, checked: W'(cnt)}); end
         end
         #1;
         checks++; if (yumi !== 4'b0100) begin errors++; $display("FAIL t3_yumi[%0d] got %b want 0100", i, yumi); end
         tick();
      end
      v = sb.pop_front();
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++; if ({done_v, done_found, done_nonce, checked} !== {1'b1, v} || yumi !== '0)
            begin errors++; $display("FAIL t3_hold[%0d] got %b/%b/%h/%0d yumi=%b want 1/%b/%h/%0d yumi=0", c, done_v, done_found, done_nonce, checked, yumi, v.found, v.nonce, v.checked); end
         tick();
      end
      done_ready = 1'b1; tick(); done_ready = 1'b0; #1;
      checks++; if (done_v !== 1'b0 || busy !== 1'b0)
         begin errors++; $display("FAIL t3_release got done_v=%b busy=%b want 0/0", done_v, busy); end
      clr_res();
   endtask

   task automatic test_abort();
      verdict_t v;
      target = '0; limit = 32'd6;
      do_start();
      for (int i = 0; i < 3; i++) begin
         clr_res(); put(1, 32'h4000 + i, 32'hFFFF0000);
         #1;
         checks++; if (yumi !== 4'b0010) begin errors++; $display("FAIL t4_pre_yumi[%0d] got %b want 0010", i, yumi); end
         tick();
      end
      checks++; if (checked !== 32'd3) begin errors++; $display("FAIL t4_pre_count got %0d want 3", checked); end
      start = 1'b1; #1;
      checks++; if (yumi !== '0) begin errors++; $display("FAIL t4_abort_yumi got %b want 0", yumi); end
      tick(); start = 1'b0; #1;
      checks++; if (checked !== '0 || busy !== 1'b1)
         begin errors++; $display("FAIL t4_restart got checked=%0d busy=%b want 0/1", checked, busy); end
      sb.push_back('{found: 1'b0, nonce: '0, checked: W'(6)});
      m_ptr = 2;
      for (int i = 0; i < 6; i++) begin
         clr_res(); put(1, 32'h4100 + i, 32'hFFFF0000);
         #1;
         checks++; if (yumi !== 4'b0010) begin errors++; $display("FAIL t4_post_yumi[%0d] got %b want 0010", i, yumi); end
         tick();
      end
      #1;
      v = sb.pop_front();
      checks++; if ({done_v, done_found, done_nonce, checked} !== {1'b1, v})
         begin errors++; $display("FAIL t4_verdict got %b/%b/%h/%0d want 1/%b/%h/%0d", done_v, done_found, done_nonce, checked, v.found, v.nonce, v.checked); end
   endtask

   task automatic test_reset_in_report();
      reset_i = 1'b1; tick(); reset_i = 1'b0; #1;
      m_ptr = 0;
      checks++; if (done_v !== 1'b0 || busy !== 1'b0 || checked !== '0)
         begin errors++; $display("FAIL t5_reset got done_v=%b busy=%b checked=%0d want 0/0/0", done_v, busy, checked); end
      checks++; if (yumi !== '0) begin errors++; $display("FAIL t5_idle_yumi got %b want 0", yumi); end
      clr_res();
   endtask

   task automatic test_limit_zero();
      target = 32'h00000010; limit = '0;
      do_start();
      for (int i = 0; i < 20; i++) begin
         clr_res(); put(3, 32'h5000 + i, 32'h00000020);
         tick();
      end
      clr_res(); #1;
      checks++; if (busy !== 1'b1 || done_v !== 1'b0 || checked !== 32'd20)
         begin errors++; $display("FAIL limit0 got busy=%b done_v=%b checked=%0d want 1/0/20", busy, done_v, checked); end
      reset_i = 1'b1; tick(); reset_i = 1'b0;
      m_ptr = 0;
   endtask

   task automatic test_best();
      logic [W-1:0] h[4];
      logic [W-1:0] tgt, n, best;
      verdict_t     v;
      int           cnt, done_at;
      bit           f;
      h = '{32'h00000500, 32'h00000100, 32'h00000100, 32'hFFFFFFFF};
      tgt = 32'h00001000; cnt = 0; done_at = -1; f = 0; n = '0; best = '1;
      target = tgt; limit = 32'd4;
      for (int i = 0; i < 4; i++) begin
         cnt++;
`ifdef BSG_NONCE_COLLECT_BEST_EN
         if (h[i] <= tgt && (!f || h[i] < best)) begin f = 1; best = h[i]; n = 32'h6000 + i; end
         if (cnt == 4) done_at = i;
`else
         if (h[i] <= tgt) begin f = 1; n = 32'h6000 + i; done_at = i; end
         else if (cnt == 4) done_at = i;
`endif
         if (done_at >= 0) break;
      end
      sb.push_back('{found: f, nonce: f ? n : '0, checked: W'(cnt)});
      do_start();
      for (int i = 0; i <= done_at; i++) begin
         clr_res(); put(0, 32'h6000 + i, h[i]);
         #1;
         checks++; if (yumi !== 4'b0001) begin errors++; $display("FAIL t6_yumi[%0d] got %b want 0001", i, yumi); end
         checks++; if (done_v !== 1'b0) begin errors++; $display("FAIL t6_early_done[%0d] got %b want 0", i, done_v); end
         tick();
      end
      clr_res(); #1;
      v = sb.pop_front();
      checks++; if ({done_v, done_found, done_nonce, checked} !== {1'b1, v})
         begin errors++; $display("FAIL t6_verdict got %b/%b/%h/%0d want 1/%b/%h/%0d", done_v, done_found, done_nonce, checked, v.found, v.nonce, v.checked); end
      done_ready = 1'b1; tick(); done_ready = 1'b0;
   endtask

   initial begin
      reset_i = 1'b1; start = 1'b0; target = '0; limit = '0; done_ready = 1'b0;
      clr_res();
      test_reset();
      test_single_hit();
      test_rr_no_hit();
      test_hold_report();
      test_abort();
      test_reset_in_report();
      test_limit_zero();
      test_best();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
